// File: rtl/fetch_decode.sv
// fetch_decode: architectural PC, instruction fetch from a synchronous BRAM, field decode and GPR/FPR operand read for exec_inner.
// Optional build macro FETCH_PERF_CNT_EN enables the retired-instruction counter on inst_count.
module fetch_decode #(
    parameter logic [31:0] PC_RESET     = 32'h0,
    parameter int          IMEM_ADDR_W  = 15,
    parameter int          IMEM_LATENCY = 1
) (
    input  logic                   clk,
    input  logic                   rstn,
    output logic [IMEM_ADDR_W-1:0] imem_addr,
    input  logic [31:0]            imem_rdata,
    output logic                   exec_enable,
    output logic [5:0]             opecode,
    output logic [4:0]             rd_no,
    output logic [4:0]             rs_no,
    output logic [4:0]             rt_no,
    output logic [15:0]            offset,
    output logic [31:0]            pc,
    output logic [31:0]            rs,
    output logic [31:0]            rt,
    output logic                   fmode1,
    output logic                   fmode2,
    input  logic                   exec_done,
    input  logic                   exec_stop,
    input  logic                   pcenable,
    input  logic [31:0]            next_pc,
    input  logic                   wenable,
    input  logic                   wfmode,
    input  logic [4:0]             wreg,
    input  logic [31:0]            wdata,
    output logic [31:0]            inst_count
);

    localparam logic [5:0] INST_J    = 6'h02;
    localparam logic [5:0] INST_FTOI = 6'h12;
    localparam logic [5:0] INST_SLTF = 6'h13;
    localparam logic [5:0] INST_BEQF = 6'h14;
    localparam logic [5:0] INST_BLTF = 6'h15;
    localparam logic [5:0] INST_ITOF = 6'h2c;

    typedef enum logic [2:0] {
        F_ADDR = 3'd0,
        F_WAIT = 3'd1,
        F_DEC  = 3'd2,
        ISSUE  = 3'd3,
        W_DONE = 3'd4
    } state_t;

    state_t      state_r;
    state_t      next_state_s;
    logic [1:0]  wcnt_r;
    logic [31:0] ir_r;
    logic [31:0] gpr_r [32];
    logic [31:0] fpr_r [32];
    logic [1:0]  bank_s;
    logic [31:0] rs_rd_s;
    logic [31:0] rt_rd_s;
    logic        latch_ir_s;
    logic        load_fields_s;
    logic        load_ops_s;
    logic [31:0] pc_next_s;

    // Bank select {fmode1, fmode2}: load/store addresses always come from the GPR file.
    function automatic logic [1:0] bank_sel(input logic [5:0] op);
        logic [1:0] sel;
        case (op)
            INST_ITOF: sel = {1'b0, op[5]};
            INST_FTOI, INST_SLTF, INST_BEQF, INST_BLTF: sel = 2'b11;
            default: begin
                if ((op[3:0] == 4'd0) || (op[3:0] == 4'd1)) begin
                    sel = {1'b0, op[5]};
                end else begin
                    sel = {op[5], op[5]};
                end
            end
        endcase
        return sel;
    endfunction

    // One read port: GPR0 is hard zero, a same-cycle write to the same register is forwarded.
    function automatic logic [31:0] read_port(input logic bank, input logic [4:0] idx,
                                              input logic [31:0] gval, input logic [31:0] fval,
                                              input logic we, input logic wbank,
                                              input logic [4:0] widx, input logic [31:0] wd);
        logic [31:0] val;
        if (!bank && (idx == 5'd0)) begin
            val = 32'h0;
        end else if (we && (wbank == bank) && (widx == idx)) begin
            val = wd;
        end else if (bank) begin
            val = fval;
        end else begin
            val = gval;
        end
        return val;
    endfunction

    assign imem_addr = pc[IMEM_ADDR_W+1:2];

    // Register file write port, not reset.
    always_ff @(posedge clk) begin
        if (wenable) begin
            if (wfmode) begin
                fpr_r[wreg] <= wdata;
            end else if (wreg != 5'd0) begin
                gpr_r[wreg] <= wdata;
            end
        end
    end

    // Operand read for the instruction held in the instruction register.
    always_comb begin
        bank_s  = bank_sel(ir_r[31:26]);
        rs_rd_s = read_port(bank_s[1], ir_r[20:16], gpr_r[ir_r[20:16]], fpr_r[ir_r[20:16]],
                            wenable, wfmode, wreg, wdata);
        rt_rd_s = read_port(bank_s[0], ir_r[15:11], gpr_r[ir_r[15:11]], fpr_r[ir_r[15:11]],
                            wenable, wfmode, wreg, wdata);
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_r <= F_ADDR;
        end else begin
            state_r <= next_state_s;
        end
    end

    // FSM next-state logic.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            F_ADDR: next_state_s = F_WAIT;
            F_WAIT: next_state_s = (wcnt_r == 2'd0) ? F_DEC : F_WAIT;
            F_DEC:  next_state_s = ISSUE;
            ISSUE:  next_state_s = exec_stop ? ISSUE : W_DONE;
            W_DONE: next_state_s = exec_done ? F_ADDR : W_DONE;
            default: next_state_s = F_ADDR;
        endcase
    end

    // FSM output decode: load strobes and next PC.
    always_comb begin
        latch_ir_s    = 1'b0;
        load_fields_s = 1'b0;
        load_ops_s    = 1'b0;
        pc_next_s     = pc;
        case (state_r)
            F_WAIT: latch_ir_s = (wcnt_r == 2'd0);
            F_DEC: begin
                load_fields_s = 1'b1;
                load_ops_s    = 1'b1;
            end
            ISSUE: load_ops_s = exec_stop;
            W_DONE: begin
                if (exec_done && pcenable) begin
                    pc_next_s = next_pc & 32'hFFFF_FFFC;
                end else if (exec_done) begin
                    pc_next_s = pc + 32'd4;
                end else begin
                    pc_next_s = pc;
                end
            end
            default: pc_next_s = pc;
        endcase
    end

    // Datapath and output registers.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            pc          <= PC_RESET;
            wcnt_r      <= 2'd0;
            ir_r        <= {INST_J, 26'd0};
            exec_enable <= 1'b0;
            opecode     <= INST_J;
            rd_no       <= 5'd0;
            rs_no       <= 5'd0;
            rt_no       <= 5'd0;
            offset      <= 16'd0;
            fmode1      <= 1'b0;
            fmode2      <= 1'b0;
            rs          <= 32'h0;
            rt          <= 32'h0;
        end else begin
            pc          <= pc_next_s;
            exec_enable <= (next_state_s == ISSUE);
            if (state_r == F_ADDR) begin
                wcnt_r <= 2'(IMEM_LATENCY - 1);
            end else if ((state_r == F_WAIT) && (wcnt_r != 2'd0)) begin
                wcnt_r <= wcnt_r - 2'd1;
            end
            if (latch_ir_s) begin
                ir_r <= imem_rdata;
            end
            if (load_fields_s) begin
                opecode <= ir_r[31:26];
                rd_no   <= ir_r[25:21];
                rs_no   <= ir_r[20:16];
                rt_no   <= ir_r[15:11];
                offset  <= ir_r[15:0];
                fmode1  <= bank_s[1];
                fmode2  <= bank_s[0];
            end
            // Operands are refreshed while exec holds the issue, so late writebacks are seen.
            if (load_ops_s) begin
                rs <= rs_rd_s;
                rt <= rt_rd_s;
            end
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] inst_count_r;
    logic        retire_s;

    assign retire_s   = (state_r == W_DONE) && exec_done;
    assign inst_count = inst_count_r;

    // Retired-instruction counter, wraps at 2^32.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            inst_count_r <= 32'h0;
        end else if (retire_s) begin
            inst_count_r <= inst_count_r + 32'd1;
        end
    end
`else
    assign inst_count = 32'h0;
`endif

endmodule

// File: tb/tb_fetch_decode.sv
// Self-checking bench for fetch_decode: directed scenarios plus a randomized instruction stream
// checked against a PC / register-file reference model.
module tb_fetch_decode;

    localparam logic [5:0] T_J    = 6'h02;
    localparam logic [5:0] T_ADDI = 6'h08;
    localparam logic [5:0] T_FTOI = 6'h12;
    localparam logic [5:0] T_SLTF = 6'h13;
    localparam logic [5:0] T_BEQF = 6'h14;
    localparam logic [5:0] T_BLTF = 6'h15;
    localparam logic [5:0] T_FADD = 6'h22;
    localparam logic [5:0] T_SWF  = 6'h21;
    localparam logic [5:0] T_ITOF = 6'h2c;

    logic        clk;
    logic        rstn;
    logic [14:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        exec_enable;
    logic [5:0]  opecode;
    logic [4:0]  rd_no, rs_no, rt_no;
    logic [15:0] offset;
    logic [31:0] pc, rs, rt;
    logic        fmode1, fmode2;
    logic        exec_done, exec_stop, pcenable;
    logic [31:0] next_pc;
    logic        wenable, wfmode;
    logic [4:0]  wreg;
    logic [31:0] wdata;
    logic [31:0] inst_count;

    int total = 0;
    int bad   = 0;

    logic [31:0] imem  [1024];
    logic [31:0] m_gpr [32];
    logic [31:0] m_fpr [32];
    logic [31:0] m_pc;
    logic [31:0] m_cnt;

    fetch_decode dut (
        .clk(clk), .rstn(rstn), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
        .exec_enable(exec_enable), .opecode(opecode), .rd_no(rd_no), .rs_no(rs_no),
        .rt_no(rt_no), .offset(offset), .pc(pc), .rs(rs), .rt(rt), .fmode1(fmode1),
        .fmode2(fmode2), .exec_done(exec_done), .exec_stop(exec_stop), .pcenable(pcenable),
        .next_pc(next_pc), .wenable(wenable), .wfmode(wfmode), .wreg(wreg), .wdata(wdata),
        .inst_count(inst_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One-cycle synchronous instruction memory.
    always @(posedge clk) imem_rdata <= imem[imem_addr[9:0]];

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

    function automatic logic [31:0] mk(input logic [5:0] op, input logic [4:0] rd,
                                       input logic [4:0] rsi, input logic [15:0] imm);
        return {op, rd, rsi, imm};
    endfunction

    function automatic logic [1:0] exp_bank(input logic [5:0] op);
        logic f1, f2;
        f1 = op[5];
        f2 = op[5];
        if (op == T_FTOI || op == T_SLTF || op == T_BEQF || op == T_BLTF) begin
            f1 = 1'b1;
            f2 = 1'b1;
        end
        if (op == T_ITOF) f1 = 1'b0;
        if (op[3:0] == 4'd0 || op[3:0] == 4'd1) f1 = 1'b0;
        return {f1, f2};
    endfunction

    function automatic logic [31:0] m_val(input logic bank, input logic [4:0] idx);
        if (bank) return m_fpr[idx];
        if (idx == 5'd0) return 32'h0;
        return m_gpr[idx];
    endfunction

    function automatic logic [31:0] exp_cnt();
`ifdef FETCH_PERF_CNT_EN
        return m_cnt;
`else
        return 32'h0;
`endif
    endfunction

    task automatic model_write(input logic wf, input logic [4:0] wr, input logic [31:0] wd);
        if (wf) m_fpr[wr] = wd;
        else if (wr != 5'd0) m_gpr[wr] = wd;
    endtask

    task automatic wait_issue(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (exec_enable !== 1'b1 && n < 20);
    endtask

    // Called at the negedge of the last ISSUE cycle; returns at the negedge of the following F_ADDR.
    task automatic finish_exec(input int dly, input logic pcen, input logic [31:0] tgt,
                               input logic we, input logic wf, input logic [4:0] wr,
                               input logic [31:0] wd);
        @(negedge clk);
        repeat (dly) @(negedge clk);
        exec_done = 1'b1; pcenable = pcen; next_pc = tgt;
        wenable = we; wfmode = wf; wreg = wr; wdata = wd;
        if (we) model_write(wf, wr, wd);
        m_pc  = pcen ? {tgt[31:2], 2'b00} : m_pc + 32'd4;
        m_cnt = m_cnt + 32'd1;
        @(negedge clk);
        exec_done = 1'b0; pcenable = 1'b0; wenable = 1'b0;
    endtask

    task automatic load_regs();
        @(negedge clk);
        for (int i = 0; i < 64; i++) begin
            wenable = 1'b1; wfmode = i[5]; wreg = i[4:0]; wdata = $urandom;
            model_write(wfmode, wreg, wdata);
            @(negedge clk);
        end
        wenable = 1'b0;
        finish_exec(0, 1'b0, 32'h0, 1'b0, 1'b0, 5'd0, 32'h0);
    endtask

    task automatic test_reset();
        int n;
        repeat (3) @(negedge clk);
        total++;
        if ({exec_enable, opecode, pc, imem_addr, rs, rt, fmode1, fmode2, inst_count} !==
            {1'b0, T_J, 32'h0, 15'h0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0}) begin
            bad++;
            $display("FAIL reset_state got en=%b op=%h pc=%h rs=%h cnt=%h exp en=0 op=%h pc=0 rs=0 cnt=0",
                     exec_enable, opecode, pc, rs, inst_count, T_J);
        end
        rstn = 1'b1;
        m_pc = 32'h0; m_cnt = 32'h0;
        wait_issue(n);
        total++;
        if (exec_enable !== 1'b1 || n != 3) begin
            bad++;
            $display("FAIL first_issue_latency got en=%b n=%0d exp en=1 n=3", exec_enable, n);
        end
        total++;
        if ({opecode, rd_no, offset, rs, pc, imem_addr, fmode1} !==
            {T_ADDI, 5'd2, 16'd5, 32'h0, 32'h0, 15'h0, 1'b0}) begin
            bad++;
            $display("FAIL first_decode got op=%h rd=%0d off=%h rs=%h pc=%h exp op=%h rd=2 off=5 rs=0 pc=0",
                     opecode, rd_no, offset, rs, pc, T_ADDI);
        end
    endtask

    task automatic test_sequential();
        int n;
        logic [31:0] inst;
        for (int k = 1; k <= 2; k++) begin
            wait_issue(n);
            inst = imem[k];
            total++;
            if (exec_enable !== 1'b1 || n != 3 || pc !== 32'(k * 4) || imem_addr !== 15'(k)) begin
                bad++;
                $display("FAIL seq_pc k=%0d got en=%b n=%0d pc=%h addr=%h exp en=1 n=3 pc=%h addr=%h",
                         k, exec_enable, n, pc, imem_addr, k * 4, k);
            end
            total++;
            if ({fmode1, fmode2, rs, rt} !== {exp_bank(inst[31:26]),
                m_val(exp_bank(inst[31:26]) >> 1, inst[20:16]),
                m_val(exp_bank(inst[31:26]) & 2'b01, inst[15:11])}) begin
                bad++;
                $display("FAIL seq_operands k=%0d got fm=%b%b rs=%h rt=%h exp fm=%b", k, fmode1, fmode2,
                         rs, rt, exp_bank(inst[31:26]));
            end
            if (k == 1) finish_exec(1, 1'b0, 32'h0, 1'b0, 1'b0, 5'd0, 32'h0);
        end
    endtask

    task automatic test_redirect();
        int n;
        finish_exec(1, 1'b1, 32'h103, 1'b0, 1'b0, 5'd0, 32'h0);
        wait_issue(n);
        total++;
        if (exec_enable !== 1'b1 || pc !== 32'h100 || imem_addr !== 15'h40) begin
            bad++;
            $display("FAIL redirect_pc got en=%b pc=%h addr=%h exp en=1 pc=100 addr=40", exec_enable, pc, imem_addr);
        end
        total++;
        if ({opecode, fmode1, fmode2, rs, rt} !== {T_ITOF, 1'b0, 1'b1, m_val(1'b0, 5'd9), m_val(1'b1, 5'd10)}) begin
            bad++;
            $display("FAIL itof_bank got op=%h fm=%b%b rs=%h rt=%h exp op=%h fm=01", opecode, fmode1, fmode2,
                     rs, rt, T_ITOF);
        end
        finish_exec(0, 1'b0, 32'h0, 1'b1, 1'b0, 5'd0, 32'h0000dead);
    endtask

    task automatic test_bypass();
        int n;
        @(negedge clk);
        @(negedge clk);
        wenable = 1'b1; wfmode = 1'b1; wreg = 5'd3; wdata = 32'h3f800000;
        model_write(1'b1, 5'd3, 32'h3f800000);
        @(negedge clk);
        wenable = 1'b0;
        total++;
        if (exec_enable !== 1'b1 || pc !== 32'h104 || rs !== 32'h3f800000 || fmode1 !== 1'b1) begin
            bad++;
            $display("FAIL fpr_bypass got en=%b pc=%h rs=%h fm1=%b exp en=1 pc=104 rs=3f800000 fm1=1",
                     exec_enable, pc, rs, fmode1);
        end
        total++;
        if (rt !== m_fpr[5]) begin
            bad++;
            $display("FAIL fadd_rt got=%h exp=%h", rt, m_fpr[5]);
        end
        finish_exec(0, 1'b0, 32'h0, 1'b0, 1'b0, 5'd0, 32'h0);
        wait_issue(n);
        total++;
        if (exec_enable !== 1'b1 || pc !== 32'h108 || rs !== 32'h0) begin
            bad++;
            $display("FAIL gpr0_write_ignored got en=%b pc=%h rs=%h exp en=1 pc=108 rs=0", exec_enable, pc, rs);
        end
        finish_exec(0, 1'b0, 32'h0, 1'b0, 1'b0, 5'd0, 32'h0);
    endtask

    task automatic test_stop_hold();
        int n, hi;
        wait_issue(n);
        total++;
        if (exec_enable !== 1'b1 || pc !== 32'h10c || rs !== m_gpr[4]) begin
            bad++;
            $display("FAIL stop_first got en=%b pc=%h rs=%h exp en=1 pc=10c rs=%h", exec_enable, pc, rs, m_gpr[4]);
        end
        hi = 1;
        exec_stop = 1'b1;
        @(negedge clk);
        if (exec_enable === 1'b1) hi++;
        wenable = 1'b1; wfmode = 1'b0; wreg = 5'd4; wdata = 32'd7;
        model_write(1'b0, 5'd4, 32'd7);
        @(negedge clk);
        if (exec_enable === 1'b1) hi++;
        wenable = 1'b0;
        @(negedge clk);
        if (exec_enable === 1'b1) hi++;
        exec_stop = 1'b0;
        total++;
        if (rs !== 32'd7) begin
            bad++;
            $display("FAIL stop_refresh got=%h exp=00000007", rs);
        end
        @(negedge clk);
        total++;
        if (exec_enable !== 1'b0 || hi != 4) begin
            bad++;
            $display("FAIL stop_enable_len got en=%b hi=%0d exp en=0 hi=4", exec_enable, hi);
        end
        finish_exec(0, 1'b0, 32'h0, 1'b0, 1'b0, 5'd0, 32'h0);
    endtask

    task automatic test_boundaries();
        int n;
        @(negedge clk);
        exec_done = 1'b1; pcenable = 1'b1; next_pc = 32'h300;
        wenable = 1'b1; wfmode = 1'b0; wreg = 5'd5; wdata = 32'h1234;
        model_write(1'b0, 5'd5, 32'h1234);
        @(negedge clk);
        exec_done = 1'b0; pcenable = 1'b0; wenable = 1'b0;
        @(negedge clk);
        total++;
        if (exec_enable !== 1'b1 || pc !== 32'h110 || rs !== 32'h1234 || inst_count !== exp_cnt()) begin
            bad++;
            $display("FAIL spurious_done got en=%b pc=%h rs=%h cnt=%h exp en=1 pc=110 rs=1234 cnt=%h",
                     exec_enable, pc, rs, inst_count, exp_cnt());
        end
        @(negedge clk);
        pcenable = 1'b1; next_pc = 32'h300;
        @(negedge clk);
        pcenable = 1'b0;
        total++;
        if (exec_enable !== 1'b0 || pc !== 32'h110) begin
            bad++;
            $display("FAIL pcenable_alone got en=%b pc=%h exp en=0 pc=110", exec_enable, pc);
        end
        finish_exec(0, 1'b0, 32'h0, 1'b0, 1'b0, 5'd0, 32'h0);
        wait_issue(n);
        finish_exec(0, 1'b1, 32'h116, 1'b0, 1'b0, 5'd0, 32'h0);
        wait_issue(n);
        total++;
        if (exec_enable !== 1'b1 || n != 3 || pc !== 32'h114) begin
            bad++;
            $display("FAIL self_loop got en=%b n=%0d pc=%h exp en=1 n=3 pc=114", exec_enable, n, pc);
        end
        finish_exec(0, 1'b1, 32'h200, 1'b0, 1'b0, 5'd0, 32'h0);
    endtask

    task automatic test_random();
        int n, r;
        logic [31:0] inst, tgt;
        logic [1:0]  bk;
        logic        pcen;
        for (int i = 0; i < 40; i++) begin
            wait_issue(n);
            inst = imem[m_pc[11:2]];
            bk = exp_bank(inst[31:26]);
            total++;
            if (exec_enable !== 1'b1 || n != 3) begin
                bad++;
                $display("FAIL rnd_issue i=%0d got en=%b n=%0d exp en=1 n=3", i, exec_enable, n);
            end
            total++;
            if ({opecode, rd_no, rs_no, rt_no, offset} !== {inst[31:11], inst[15:0]}) begin
                bad++;
                $display("FAIL rnd_fields i=%0d got op=%h rd=%h rs=%h rt=%h off=%h exp inst=%h",
                         i, opecode, rd_no, rs_no, rt_no, offset, inst);
            end
            total++;
            if ({pc, imem_addr} !== {m_pc, m_pc[16:2]}) begin
                bad++;
                $display("FAIL rnd_pc i=%0d got pc=%h addr=%h exp pc=%h", i, pc, imem_addr, m_pc);
            end
            total++;
            if ({fmode1, fmode2, rs, rt} !== {bk, m_val(bk[1], inst[20:16]), m_val(bk[0], inst[15:11])}) begin
                bad++;
                $display("FAIL rnd_operands i=%0d got fm=%b%b rs=%h rt=%h exp fm=%b rs=%h rt=%h", i, fmode1,
                         fmode2, rs, rt, bk, m_val(bk[1], inst[20:16]), m_val(bk[0], inst[15:11]));
            end
            total++;
            if (inst_count !== exp_cnt()) begin
                bad++;
                $display("FAIL rnd_count i=%0d got=%h exp=%h", i, inst_count, exp_cnt());
            end
            r = $urandom_range(0, 3);
            pcen = (r < 2);
            tgt = (r == 0) ? (m_pc | 32'($urandom_range(0, 3)))
                           : 32'h200 + (32'($urandom_range(0, 511)) << 2) + 32'($urandom_range(0, 3));
            finish_exec($urandom_range(0, 2), pcen, tgt, 1'($urandom_range(0, 1)),
                        1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom);
        end
    endtask

    task automatic test_reset_mid();
        int n;
        wait_issue(n);
        @(negedge clk);
        rstn = 1'b0; exec_done = 1'b1; pcenable = 1'b1; next_pc = 32'h500;
        @(negedge clk);
        total++;
        if ({exec_enable, pc, inst_count, opecode, rd_no, rs_no, offset, rs, rt, fmode1, fmode2} !==
            {1'b0, 32'h0, 32'h0, T_J, 5'd0, 5'd0, 16'd0, 32'h0, 32'h0, 1'b0, 1'b0}) begin
            bad++;
            $display("FAIL mid_reset got en=%b pc=%h cnt=%h op=%h rs=%h exp en=0 pc=0 cnt=0 op=%h rs=0",
                     exec_enable, pc, inst_count, opecode, rs, T_J);
        end
        @(negedge clk);
        exec_done = 1'b0; pcenable = 1'b0; rstn = 1'b1;
        m_pc = 32'h0; m_cnt = 32'h0;
        wait_issue(n);
        total++;
        if (exec_enable !== 1'b1 || n != 3 || pc !== 32'h0 || opecode !== T_ADDI) begin
            bad++;
            $display("FAIL mid_reset_refetch got en=%b n=%0d pc=%h op=%h exp en=1 n=3 pc=0 op=%h",
                     exec_enable, n, pc, opecode, T_ADDI);
        end
    endtask

    task automatic test_counter();
        int n;
        for (int k = 0; k < 5; k++) begin
            finish_exec($urandom_range(0, 2), 1'b0, 32'h0, 1'b0, 1'b0, 5'd0, 32'h0);
            wait_issue(n);
        end
        total++;
        if (inst_count !== exp_cnt() || m_cnt != 32'd5) begin
            bad++;
            $display("FAIL counter_five got=%h exp=%h", inst_count, exp_cnt());
        end
    endtask

    initial begin
        rstn = 1'b0; exec_done = 1'b0; exec_stop = 1'b0; pcenable = 1'b0; next_pc = 32'h0;
        wenable = 1'b0; wfmode = 1'b0; wreg = 5'd0; wdata = 32'h0;
        m_pc = 32'h0; m_cnt = 32'h0;
        for (int i = 0; i < 32; i++) begin
            m_gpr[i] = 32'h0;
            m_fpr[i] = 32'h0;
        end
        for (int i = 0; i < 1024; i++) imem[i] = $urandom;
        imem[0]     = mk(T_ADDI, 5'd2, 5'd0, 16'd5);
        imem[1]     = mk(T_SWF,  5'd3, 5'd4, 16'h2800);
        imem[2]     = mk(T_FTOI, 5'd6, 5'd7, 16'h4000);
        imem[10'h40] = mk(T_ITOF, 5'd1, 5'd9, 16'h5000);
        imem[10'h41] = mk(T_FADD, 5'd1, 5'd3, 16'h2800);
        imem[10'h42] = mk(T_ADDI, 5'd7, 5'd0, 16'h0);
        imem[10'h43] = mk(T_ADDI, 5'd9, 5'd4, 16'd1);
        imem[10'h44] = mk(T_ADDI, 5'd6, 5'd5, 16'd2);

        test_reset();
        load_regs();
        test_sequential();
        test_redirect();
        test_bypass();
        test_stop_hold();
        test_boundaries();
        test_random();
        test_reset_mid();
        test_counter();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
